eq_ui_controller: RTL and testbench
===================================

Name: eq_ui_controller

Overview:
User-interface sequencer for the graphic equalizer. It turns debounced push-button levels into a mode state machine and a band cursor. It holds a 6-entry per-band gain register file and drives the state/band/gain inputs of the seven-segment decoder. Changed band gains are scheduled onto a valid/ready config channel toward the EQ datapath, one band per transfer.

Parameters:
NUM_BANDS, 6, number of EQ bands; band index runs 1..NUM_BANDS
GAIN_MAX, 12, gain saturation magnitude in dB; range is -GAIN_MAX..+GAIN_MAX
TIMEOUT_CYCLES, 250_000_000, idle cycles in BAND/GAIN before falling back to BANNER (5 s at 50 MHz)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_key_mode  in  1  debounced level, active high; cycles the mode
i_key_sel  in  1  debounced level; select / clear
i_key_up  in  1  debounced level; increment
i_key_down  in  1  debounced level; decrement
o_state  out  3  display mode to the decoder
o_band  out  3  current band cursor, 1..6
o_gain  out  32  current band's gain, two's complement, sign-extended
o_band_gain  out  30  packed gains, 5-bit signed each; band b occupies bits [5b-1:5b-5]
o_cfg_valid  out  1  config transfer pending
o_cfg_band  out  3  band of the pending transfer
o_cfg_gain  out  5  signed gain of the pending transfer
i_cfg_ready  in  1  datapath accepts the transfer

Behaviour:
- Reset values (async, i_rst_n low): o_state=OFF(0), o_band=1, all gains 0, o_cfg_valid=0, o_cfg_band=1, o_cfg_gain=0, timeout counter 0, key history 0.
- Key handling:
  - Each key is registered twice (q, qq); press = q & ~qq.
  - An input first sampled high at edge 0 takes effect in state/band/gain at edge 2.
  - Holding a key produces exactly one press.
- Simultaneous presses in one cycle: only the highest priority acts (mode > sel > up > down); the others are dropped.
- FSM, with o_state values:
  - OFF(0): display dark; any press goes to BANNER.
  - BANNER(1): mode goes to BAND; other keys are ignored.
  - BAND(2): mode goes to GAIN; sel goes to GAIN; up/down move the cursor (up 6->1 wraps, down 1->6 wraps).
  - GAIN(3): up/down change the current band's gain with saturation at +12/-12 (no wrap); sel clears that gain to 0; mode goes to BAND.
- Timeout:
  - The counter clears on any press and on every state change.
  - In BAND or GAIN, when the counter reaches TIMEOUT_CYCLES-1 with no press that cycle, the next state is BANNER and the counter clears.
  - In OFF/BANNER the counter holds at 0.
  - A press in the terminal cycle wins over the timeout.
- o_gain is always the sign extension of the current band's gain, including in OFF/BANNER.
- Dirty scheduling:
  - A 6-bit dirty mask sets a band's bit at the edge its gain value changes.
  - Saturated up/down and clearing an already-zero gain are not changes, so they set no bit.
- Config emitter:
  - If o_cfg_valid=0 and the mask is nonzero, the emitter loads the lowest-index dirty band and its current gain at the next edge and asserts o_cfg_valid. Latency from the gain change to valid is 1 cycle.
  - Payload is frozen while valid and not ready.
  - Transfer completes on an edge with valid & i_cfg_ready. That band's dirty bit clears, unless the same band is edited at that same edge, in which case the bit stays set.
  - o_cfg_valid drops for exactly one cycle between transfers (no back-to-back).
  - Edits to the pending band during a stall are not lost: its bit is re-set and it is resent later with the new value.
- No combinational path from i_cfg_ready to any output.

Decomposition:
- Package eq_ui_pkg holds:
  - state_t enum {ST_OFF=0, ST_BANNER=1, ST_BAND=2, ST_GAIN=3}, 3 bits
  - gain_t as logic signed [4:0]
  - constants NUM_BANDS, GAIN_MAX
  - priority-encode function lowest_set(mask)
- One sub-module, key_edge_detect: the 2-flop register plus rising-edge pulse for one key, instantiated four times.

Test Plan:
- Reset, then one press each of mode, mode, mode, mode: o_state goes 0->1->2->3->2; o_band=1; o_gain=0; no cfg traffic.
- In GAIN, up x14 with i_cfg_ready=1: gain saturates at 12 (o_gain=32'd12).
  - 12 transfers occur, the last with band=1, gain=12.
  - Presses 13 and 14 produce no valid.
- In GAIN, down x3: o_gain=32'hFFFF_FFFD. Then sel: gain 0 and one transfer with gain=0. Then sel again: no transfer.
- In BAND, with down then up x7: down gives band 6, and the subsequent ups walk 1..6 then back to 1 with wraparound.
- i_cfg_ready=0 while editing bands 4, then 2, then 4 again (+1 each):
  - o_cfg_valid holds band 4, gain 1, stable.
  - After ready=1, transfers follow in order band 2 (gain 1), then band 4 (gain 2).
- TIMEOUT_CYCLES=16, enter GAIN, no presses: o_state=1 after 16 cycles.
  - Repeat with an up press at cycle 15: stays in GAIN and the counter restarts.
  - Assert i_rst_n low mid-transfer: all outputs return to reset values immediately.

Source files
------------

// File: rtl/eq_ui_pkg.sv
// Shared types and constants for the equalizer user-interface controller.
package eq_ui_pkg;

  localparam int NUM_BANDS = 6;
  localparam int GAIN_MAX  = 12;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_BANNER = 3'd1,
    ST_BAND   = 3'd2,
    ST_GAIN   = 3'd3
  } state_t;

  typedef logic signed [4:0] gain_t;
  typedef logic [2:0]        band_t;

  localparam gain_t GAIN_HI   = gain_t'(GAIN_MAX);
  localparam gain_t GAIN_LO   = gain_t'(-GAIN_MAX);
  localparam band_t BAND_LAST = band_t'(NUM_BANDS);

  // Returns the 1-based index of the lowest set bit, or 0 for an empty mask.
  function automatic band_t lowest_set(input logic [NUM_BANDS-1:0] mask);
    band_t idx;
    idx = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (mask[i]) idx = band_t'(i + 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/eq_ui_controller_key_edge_detect.sv
// Two-stage key register with a registered rising-edge pulse; a held key
// yields a single one-cycle press.
module key_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_press
);

  logic key_q, key_qq, press_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      key_q   <= 1'b0;
      key_qq  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      key_q   <= i_key;
      key_qq  <= key_q;
      press_q <= key_q & ~key_qq;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/eq_ui_controller.sv
// Equalizer UI sequencer: mode FSM, band cursor, per-band gain registers and
// a valid/ready emitter that pushes changed gains to the datapath.
module eq_ui_controller
  import eq_ui_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_key_mode,
  input  logic        i_key_sel,
  input  logic        i_key_up,
  input  logic        i_key_down,
  output logic [2:0]  o_state,
  output logic [2:0]  o_band,
  output logic [31:0] o_gain,
  output logic [29:0] o_band_gain,
  output logic        o_cfg_valid,
  output logic [2:0]  o_cfg_band,
  output logic [4:0]  o_cfg_gain,
  input  logic        i_cfg_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [3:0] key_lvl, press;
  logic       p_mode, p_sel, p_up, p_down, any_press;

  state_t           state_q;
  band_t            band_q;
  logic [CNT_W-1:0] cnt_q;

  gain_t                gains [NUM_BANDS];
  gain_t                cur_gain;
  logic                 gain_wr;
  gain_t                gain_wdata;
  logic [NUM_BANDS-1:0] edit_mask;

  logic [NUM_BANDS-1:0] dirty_q, dirty_d, load_mask;
  band_t                next_band;
  logic                 cfg_valid_q, cfg_valid_d;
  band_t                cfg_band_q, cfg_band_d;
  gain_t                cfg_gain_q, cfg_gain_d;

  assign key_lvl = {i_key_mode, i_key_sel, i_key_up, i_key_down};

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_edge_detect u_key (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key   (key_lvl[gi]),
      .o_press (press[gi])
    );
  end

  // Only the highest-priority key acts when several fire together.
  assign p_mode    = press[3];
  assign p_sel     = press[2] & ~press[3];
  assign p_up      = press[1] & ~|press[3:2];
  assign p_down    = press[0] & ~|press[3:1];
  assign any_press = |press;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_OFF;
      band_q  <= band_t'(1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_OFF:    if (any_press) state_q <= ST_BANNER;
        ST_BANNER: if (p_mode) state_q <= ST_BAND;
        ST_BAND: begin
          if (p_mode || p_sel) state_q <= ST_GAIN;
          else if (p_up)   band_q <= (band_q == BAND_LAST) ? band_t'(1) : band_q + band_t'(1);
          else if (p_down) band_q <= (band_q == band_t'(1)) ? BAND_LAST : band_q - band_t'(1);
        end
        ST_GAIN:   if (p_mode) state_q <= ST_BAND;
        default:   state_q <= ST_OFF;
      endcase
      // A press in the terminal cycle resets the count before the timeout can fire.
      if (state_q == ST_BAND || state_q == ST_GAIN) begin
        if (any_press) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          state_q <= ST_BANNER;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign cur_gain = gains[band_q - band_t'(1)];

  always_comb begin
    gain_wr    = 1'b0;
    gain_wdata = cur_gain;
    if (state_q == ST_GAIN) begin
      if (p_sel) begin
        gain_wr    = (cur_gain != gain_t'(0));
        gain_wdata = '0;
      end else if (p_up && (cur_gain < GAIN_HI)) begin
        gain_wr    = 1'b1;
        gain_wdata = cur_gain + gain_t'(1);
      end else if (p_down && (cur_gain > GAIN_LO)) begin
        gain_wr    = 1'b1;
        gain_wdata = cur_gain - gain_t'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_band
    gain_t band_gain_q;

    assign edit_mask[gi] = gain_wr && (band_q == band_t'(gi + 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)          band_gain_q <= '0;
      else if (edit_mask[gi]) band_gain_q <= gain_wdata;
    end

    assign gains[gi]             = band_gain_q;
    assign o_band_gain[5*gi +: 5] = band_gain_q;
  end

  assign next_band = lowest_set(dirty_q);

  // The loaded band's bit is dropped at load time, so any edit made while the
  // transfer stalls re-marks it and the newer value is sent afterwards.
  always_comb begin
    cfg_valid_d = cfg_valid_q;
    cfg_band_d  = cfg_band_q;
    cfg_gain_d  = cfg_gain_q;
    load_mask   = '0;
    if (cfg_valid_q) begin
      if (i_cfg_ready) cfg_valid_d = 1'b0;
    end else if (|dirty_q) begin
      cfg_valid_d = 1'b1;
      cfg_band_d  = next_band;
      cfg_gain_d  = gains[next_band - band_t'(1)];
      load_mask[next_band - band_t'(1)] = 1'b1;
    end
    dirty_d = (dirty_q & ~load_mask) | edit_mask;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dirty_q     <= '0;
      cfg_valid_q <= 1'b0;
      cfg_band_q  <= band_t'(1);
      cfg_gain_q  <= '0;
    end else begin
      dirty_q     <= dirty_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_band_q  <= cfg_band_d;
      cfg_gain_q  <= cfg_gain_d;
    end
  end

  assign o_state     = state_q;
  assign o_band      = band_q;
  assign o_gain      = {{27{cur_gain[4]}}, cur_gain};
  assign o_cfg_valid = cfg_valid_q;
  assign o_cfg_band  = cfg_band_q;
  assign o_cfg_gain  = cfg_gain_q;

endmodule

// File: tb/tb_eq_ui_controller.sv
// Scoreboard bench for eq_ui_controller: expected config transfers are queued
// as edits are made and popped when the DUT completes a handshake.
module tb_eq_ui_controller;

  localparam int TO = 16;
  localparam logic [3:0] K_MODE = 4'b1000;
  localparam logic [3:0] K_SEL  = 4'b0100;
  localparam logic [3:0] K_UP   = 4'b0010;
  localparam logic [3:0] K_DOWN = 4'b0001;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  keys = '0;
  logic        i_cfg_ready = 1'b1;
  logic [2:0]  o_state, o_band, o_cfg_band;
  logic [31:0] o_gain;
  logic [29:0] o_band_gain;
  logic        o_cfg_valid;
  logic [4:0]  o_cfg_gain;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];
  logic [7:0] mon_e;
  logic       prev_hs = 1'b0;
  int         m_gain [1:6];
  int         m_band;

  eq_ui_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_key_mode  (keys[3]),
    .i_key_sel   (keys[2]),
    .i_key_up    (keys[1]),
    .i_key_down  (keys[0]),
    .o_state     (o_state),
    .o_band      (o_band),
    .o_gain      (o_gain),
    .o_band_gain (o_band_gain),
    .o_cfg_valid (o_cfg_valid),
    .o_cfg_band  (o_cfg_band),
    .o_cfg_gain  (o_cfg_gain),
    .i_cfg_ready (i_cfg_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every completed handshake must match the oldest queued transfer,
  // and valid must be low on the cycle right after a handshake.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) check("cfg_gap", 32'(o_cfg_valid), 32'd0);
      prev_hs = o_cfg_valid && i_cfg_ready;
      if (o_cfg_valid && i_cfg_ready) begin
        if (sb_q.size() == 0) begin
          check("cfg_unexpected", 32'(o_cfg_valid), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("xfer band=%0d gain=%0d", o_cfg_band, $signed(o_cfg_gain));
          check("cfg_band", 32'(o_cfg_band), 32'(mon_e[7:5]));
          check("cfg_gain", 32'(o_cfg_gain), 32'(mon_e[4:0]));
        end
      end
    end
  end

  task automatic press_keys(input logic [3:0] k, input int hold);
    keys = k;
    repeat (hold) @(posedge i_clk);
    #1 keys = '0;
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic step_state(input logic [3:0] k, input int exp_state);
    press_keys(k, 2);
    check("state", 32'(o_state), 32'(exp_state));
  endtask

  task automatic nav(input logic [3:0] k, input int exp_band);
    press_keys(k, 2);
    m_band = exp_band;
    check("band", 32'(o_band), 32'(exp_band));
  endtask

  task automatic edit(input logic [3:0] k);
    int g;
    int n;
    g = m_gain[m_band];
    n = g;
    if (k == K_UP && g < 12)        n = g + 1;
    else if (k == K_DOWN && g > -12) n = g - 1;
    else if (k == K_SEL)            n = 0;
    if (n != g) begin
      m_gain[m_band] = n;
      sb_q.push_back({3'(m_band), 5'(n)});
    end
    press_keys(k, 2);
    $display("edit band=%0d gain=%0d", m_band, n);
    check("gain", o_gain, 32'(n));
  endtask

  task automatic check_reset(input string p);
    check({p, "_state"},     32'(o_state), 32'd0);
    check({p, "_band"},      32'(o_band), 32'd1);
    check({p, "_gain"},      o_gain, 32'd0);
    check({p, "_band_gain"}, 32'(o_band_gain), 32'd0);
    check({p, "_cfg_valid"}, 32'(o_cfg_valid), 32'd0);
    check({p, "_cfg_band"},  32'(o_cfg_band), 32'd1);
    check({p, "_cfg_gain"},  32'(o_cfg_gain), 32'd0);
  endtask

  task automatic check_stall(input string p);
    check({p, "_valid"}, 32'(o_cfg_valid), 32'd1);
    check({p, "_band"},  32'(o_cfg_band), 32'd4);
    check({p, "_gain"},  32'(o_cfg_gain), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_band = 1;
    for (int b = 1; b <= 6; b++) m_gain[b] = 0;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset("rst");
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Mode walk; first press held long to show it counts once.
    press_keys(K_MODE, 8);
    check("state_hold", 32'(o_state), 32'd1);
    step_state(K_MODE, 2);
    step_state(K_MODE, 3);
    step_state(K_MODE, 2);
    check("band_walk", 32'(o_band), 32'd1);
    check("gain_walk", o_gain, 32'd0);

    // Gain editing on band 1 with the datapath always ready.
    step_state(K_SEL, 3);
    for (int i = 0; i < 14; i++) edit(K_UP);
    check("gain_sat_hi", o_gain, 32'd12);
    check("band1_packed", 32'(o_band_gain[4:0]), 32'd12);
    edit(K_SEL);
    for (int i = 0; i < 3; i++) edit(K_DOWN);
    check("gain_neg3", o_gain, 32'hFFFF_FFFD);
    edit(K_SEL);
    edit(K_SEL);
    for (int i = 0; i < 13; i++) edit(K_DOWN);
    check("gain_sat_lo", o_gain, 32'hFFFF_FFF4);
    edit(K_SEL);

    // Cursor wraparound in both directions.
    step_state(K_MODE, 2);
    nav(K_DOWN, 6);
    for (int i = 1; i <= 7; i++) nav(K_UP, ((i - 1) % 6) + 1);

    // Simultaneous presses: mode beats up, then sel beats up.
    press_keys(K_MODE | K_UP, 2);
    check("prio_state", 32'(o_state), 32'd3);
    check("prio_band", 32'(o_band), 32'd1);
    press_keys(K_SEL | K_UP, 2);
    check("prio_gain", o_gain, 32'd0);
    step_state(K_MODE, 2);
    nav(K_UP, 2);
    nav(K_UP, 3);
    nav(K_UP, 4);

    // Stalled datapath while editing bands 4, 2, 4.
    step_state(K_MODE, 3);
    i_cfg_ready = 1'b0;
    edit(K_UP);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check_stall("stall_a");
    end
    step_state(K_MODE, 2);
    nav(K_DOWN, 3);
    nav(K_DOWN, 2);
    step_state(K_MODE, 3);
    edit(K_UP);
    @(negedge i_clk);
    check_stall("stall_b");
    step_state(K_MODE, 2);
    nav(K_UP, 3);
    nav(K_UP, 4);
    step_state(K_MODE, 3);
    edit(K_UP);
    @(negedge i_clk);
    check_stall("stall_c");
    @(posedge i_clk);
    #1 i_cfg_ready = 1'b1;

    // Idle timeout out of GAIN.
    step_state(K_MODE, 2);
    step_state(K_MODE, 3);
    repeat (13) @(posedge i_clk);
    @(negedge i_clk);
    check("to_before", 32'(o_state), 32'd3);
    @(posedge i_clk);
    @(negedge i_clk);
    check("to_fire", 32'(o_state), 32'd1);

    // A press landing in the terminal cycle wins and restarts the count.
    step_state(K_MODE, 2);
    step_state(K_MODE, 3);
    repeat (11) @(posedge i_clk);
    #1 keys = K_UP;
    m_gain[4] = 3;
    sb_q.push_back({3'd4, 5'd3});
    repeat (2) @(posedge i_clk);
    #1 keys = '0;
    @(negedge i_clk);
    check("term_pre", 32'(o_state), 32'd3);
    @(posedge i_clk);
    @(negedge i_clk);
    check("term_state", 32'(o_state), 32'd3);
    check("term_gain", o_gain, 32'd3);
    repeat (15) @(posedge i_clk);
    @(negedge i_clk);
    check("restart_before", 32'(o_state), 32'd3);
    @(posedge i_clk);
    @(negedge i_clk);
    check("restart_fire", 32'(o_state), 32'd1);
    check("packed_all", 32'(o_band_gain), 32'((30'd3 << 15) | (30'd1 << 5)));
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset while a transfer is pending.
    step_state(K_MODE, 2);
    step_state(K_MODE, 3);
    @(posedge i_clk);
    #1 i_cfg_ready = 1'b0;
    press_keys(K_UP, 2);
    check("pre_rst_gain", o_gain, 32'd4);
    @(negedge i_clk);
    check("pre_rst_valid", 32'(o_cfg_valid), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check_reset("async");
    for (int b = 1; b <= 6; b++) m_gain[b] = 0;
    m_band = 1;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    i_cfg_ready = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    step_state(K_UP, 1);
    check("post_band", 32'(o_band), 32'd1);
    check("post_gain", o_gain, 32'd0);
    check("post_packed", 32'(o_band_gain), 32'd0);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    check("sb_left", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
